ddr_deser: RTL and testbench
============================

// Module: ddr_deser
// PURPOSE
//  Receive-side counterpart of the DDR output path. Samples a W_PAD-bit pad bus on both clock edges and
//  packs BEATS consecutive {rise,fall} beats into one word. Presents each word on a valid/ready stream
//  through a 2-entry buffer. Sits between input pads (e.g. a parallel LCD/flash/camera-style bus) and a
//  system-clock consumer.
// PARAMETERS
//  W_PAD   4  pad bus width; each clk cycle yields 2*W_PAD bits
//  BEATS   4  clk cycles (beats) per output word, >= 1
//  W_WORD  derived localparam = 2*W_PAD*BEATS; not overridable
// PORTS
//  clk          in   1       sole clock; all logic on posedge, except the fall-sample register on negedge
//  rst          in   1       asynchronous, active-high reset
//  pad_in       in   W_PAD   DDR data from pads
//  en           in   1       capture enable; sampled with pad_in at the same rising edge
//  sync         in   1       word alignment marker; sampled with pad_in at the same rising edge
//  out_data     out  W_WORD  assembled word (head of buffer)
//  out_valid    out  1       buffer non-empty
//  out_ready    in   1       consumer accepts head when out_valid && out_ready at posedge
//  overflow     out  1       sticky: a completed word was dropped
//  clr_overflow in   1       clears overflow
// BEHAVIOUR
//  Reset: every register cleared, including the negedge register. out_valid=0, out_data=0, overflow=0.
//   Beat counter=0, buffer empty.
//  Capture: beat k = {F_k, R_k}. R_k = pad_in at posedge k. F_k = pad_in at the following negedge. R_k is
//   in the low bits (earlier sample low).
//  Beat k is registered at posedge k+1 together with en_k and sync_k (delayed one cycle with R_k).
//  Gearbox: beat counter 0..BEATS-1. Beat with counter c goes to word bits [2*W_PAD*(c+1)-1 : 2*W_PAD*c].
//   - en_k=0: counter forced to 0; the partial word is discarded; no push.
//   - sync_k=1 (with en_k=1): this beat becomes beat 0 and the partial word is discarded. sync wins over
//     the counter value.
//   - The beat landing at counter=BEATS-1 completes the word and pushes it into the buffer at posedge k+2.
//     The counter then wraps to 0.
//   - BEATS=1: every enabled beat is a complete word.
//  Latency: rise edge of the last beat at posedge k -> out_valid=1 and out_data valid after posedge k+2
//   (buffer previously empty).
//  Buffer: 2-entry FIFO; out_data is driven from the head register. No combinational path from out_ready
//   to any output.
//   - Push while count=2 and no pop that cycle: word dropped, contents unchanged, overflow<=1.
//   - Push and pop in the same cycle at count=2: pop frees a slot, push accepted, no overflow.
//   - Push and pop at count=1: count stays 1 and the new word becomes head.
//   - Pop at count=0: ignored.
//  overflow: set has priority over a clr_overflow in the same cycle; otherwise clr_overflow clears it
//   at the next posedge.
//  Reset mid-word or mid-stream: all state, including buffered words, is discarded immediately (async).
//   After release, the first word needs a full BEATS enabled beats counted from the first enabled beat or
//   from sync.
// STRUCTURE
//  No shared package; W_WORD and beat bit ordering are local to this module.
//  Sub-module ddr_in (clk, rst, pad, q_rise, q_fall), W_PAD wide: the capture primitive.
//   - Generic form: posedge + negedge flops, fall retimed to posedge.
//   - Under `ifdef DDRIN_ICE40: SB_IO in DDR-input mode, fed by the same timing contract.
//  Gearbox, counter and buffer live in ddr_deser (no further sub-modules).
// TESTING (W_PAD=4, BEATS=2, W_WORD=16)
//  1. en=1, sync=1 with rise 0x1; fall 0x2; next cycle rise 0x3, fall 0x4; out_ready=1
//     -> out_data=16'h4321, out_valid high exactly 2 cycles after the rise edge of 0x3, for one cycle.
//  2. Stream nibbles 0..F continuously with sync on nibble 0 and out_ready=1
//     -> words 0x3210, 0x7654, 0xBA98, 0xFEDC on consecutive odd cycles; no overflow.
//  3. out_ready=0, three complete words W0..W2 -> overflow=1, W2 dropped.
//     Then out_ready=1 -> W0 then W1 delivered. Pulse clr_overflow -> overflow=0.
//  4. Buffer full and out_ready=1 in the cycle a new word completes -> no overflow; order W0, W1, W2 preserved.
//  5. en drops after one beat (0x1,0x2), then returns with sync on 0x5,0x6,0x7,0x8
//     -> only 16'h8765 emitted. sync mid-word likewise restarts alignment.
//  6. Assert rst between beat 0 and beat 1, and with 2 words buffered
//     -> out_valid=0, overflow=0 immediately. Next word needs 2 fresh beats after release.

Source files
------------

// File: rtl/ddr_deser_if.sv
// Output stream of ddr_deser: assembled word with valid/ready handshake.
interface ddr_deser_if #(
  parameter int unsigned W_WORD = 32
);
  logic [W_WORD-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ddr_in.sv
// DDR input capture: rise sample on posedge, fall sample on negedge, both retimed
// to the following posedge so q_rise/q_fall hold beat k after posedge k+1.
module ddr_in #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pad,
  output logic [W-1:0] q_rise,
  output logic [W-1:0] q_fall
);
  logic [W-1:0] rise_s;
  logic [W-1:0] fall_s;

`ifdef DDRIN_ICE40
  for (genvar i = 0; i < W; i++) begin : g_io
    SB_IO #(
      .PIN_TYPE(6'b000000)
    ) u_io (
      .PACKAGE_PIN(pad[i]),
      .INPUT_CLK  (clk),
      .D_IN_0     (rise_s[i]),
      .D_IN_1     (fall_s[i])
    );
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rise_s <= '0;
    else     rise_s <= pad;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) fall_s <= '0;
    else     fall_s <= pad;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rise <= '0;
      q_fall <= '0;
    end else begin
      q_rise <= rise_s;
      q_fall <= fall_s;
    end
  end
endmodule

// File: rtl/ddr_deser.sv
// DDR deserializer: packs BEATS {fall,rise} beats into one word, with sync-based
// alignment and a 2-entry output buffer with sticky overflow.
module ddr_deser #(
  parameter int unsigned W_PAD = 4,
  parameter int unsigned BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_PAD-1:0] pad_in,
  input  logic             en,
  input  logic             sync,
  ddr_deser_if.master      stream,
  output logic             overflow,
  input  logic             clr_overflow
);
  localparam int unsigned BW     = 2 * W_PAD;
  localparam int unsigned W_WORD = BW * BEATS;
  localparam int unsigned CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  logic [W_PAD-1:0]  q_rise, q_fall;
  logic              en_d, sync_d, en_q, sync_q;
  logic [BW-1:0]     beat;
  logic [CW-1:0]     cnt, eff_cnt;
  logic [W_WORD-1:0] partial, word_next, head, tail;
  logic              complete, pop, drop;
  occ_t              occ;

  ddr_in #(.W(W_PAD)) u_ddr_in (
    .clk   (clk),
    .rst   (rst),
    .pad   (pad_in),
    .q_rise(q_rise),
    .q_fall(q_fall)
  );

  assign beat = {q_fall, q_rise};

  // en/sync travel two stages so they line up with the retimed beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d   <= 1'b0;
      sync_d <= 1'b0;
      en_q   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      en_d   <= en;
      sync_d <= sync;
      en_q   <= en_d;
      sync_q <= sync_d;
    end
  end

  always_comb begin
    eff_cnt   = sync_q ? '0 : cnt;
    word_next = partial;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (eff_cnt == CW'(i)) word_next[i*BW +: BW] = beat;
    end
    complete = en_q && (eff_cnt == CW'(BEATS - 1));
    pop      = stream.out_ready && (occ != EMPTY);
    drop     = complete && (occ == FULL) && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      partial  <= '0;
      head     <= '0;
      tail     <= '0;
      occ      <= EMPTY;
      overflow <= 1'b0;
    end else begin
      if (!en_q || complete) cnt <= '0;
      else                   cnt <= eff_cnt + CW'(1);
      if (en_q) partial <= word_next;

      unique case (occ)
        EMPTY: if (complete) begin
          head <= word_next;
          occ  <= ONE;
        end
        ONE: begin
          if (complete) begin
            if (pop) head <= word_next;
            else begin
              tail <= word_next;
              occ  <= FULL;
            end
          end else if (pop) occ <= EMPTY;
        end
        FULL: if (pop) begin
          head <= tail;
          if (complete) tail <= word_next;
          else          occ  <= ONE;
        end
        default: occ <= EMPTY;
      endcase

      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign stream.out_data  = head;
  assign stream.out_valid = (occ != EMPTY);
endmodule

// File: tb/tb_ddr_deser.sv
// Randomized and directed bench for ddr_deser (W_PAD=4, BEATS=2) against a queue-based model.
module tb_ddr_deser;
  localparam int unsigned W_PAD  = 4;
  localparam int unsigned BEATS  = 2;
  localparam int unsigned BW     = 2 * W_PAD;
  localparam int unsigned W_WORD = BW * BEATS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [W_PAD-1:0] pad_in = '0;
  logic             en = 1'b0;
  logic             sync = 1'b0;
  logic             overflow;
  logic             clr_overflow = 1'b0;

  ddr_deser_if #(.W_WORD(W_WORD)) bus ();

  ddr_deser #(.W_PAD(W_PAD), .BEATS(BEATS)) dut (
    .clk         (clk),
    .rst         (rst),
    .pad_in      (pad_in),
    .en          (en),
    .sync        (sync),
    .stream      (bus),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: beats collected in a queue, completed words land in the
  // buffer two posedges after the rise edge of their last beat.
  int unsigned       n = 0;
  bit                pv[4];
  logic [W_WORD-1:0] pw[4];
  logic [W_WORD-1:0] q[$];
  logic [BW-1:0]     bq[$];
  bit                m_ovf = 1'b0;

  task automatic model_clear();
    q.delete();
    bq.delete();
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] f, input logic e,
                            input logic s, input logic rdy, input logic clr);
    bit drop;
    int unsigned idx;
    logic [W_WORD-1:0] w;
    drop = 1'b0;
    if (rdy && q.size() > 0) void'(q.pop_front());
    idx = n % 4;
    if (pv[idx]) begin
      pv[idx] = 1'b0;
      if (q.size() < 2) q.push_back(pw[idx]);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (!e) bq.delete();
    else begin
      if (s) bq.delete();
      bq.push_back({f, r});
      if (bq.size() == BEATS) begin
        w = '0;
        foreach (bq[i]) w = w | (W_WORD'(bq[i]) << (BW * i));
        pv[(n + 2) % 4] = 1'b1;
        pw[(n + 2) % 4] = w;
        bq.delete();
      end
    end
    n++;
  endtask

  // Entered 2 time units before a posedge; returns at the same phase one cycle later.
  task automatic cycle(input logic [3:0] r, input logic [3:0] f, input logic e,
                       input logic s, input logic rdy, input logic clr);
    pad_in = r; en = e; sync = s; bus.out_ready = rdy; clr_overflow = clr;
    @(posedge clk);
    model_step(r, f, e, s, rdy, clr);
    #1;
    check("valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("data", 32'(bus.out_data), 32'(q[0]));
    check("overflow", 32'(overflow), 32'(m_ovf));
    #2 pad_in = f;
    #5;
  endtask

  task automatic idle(input logic rdy, input logic clr);
    cycle(4'h0, 4'h0, 1'b0, 1'b0, rdy, clr);
  endtask

  task automatic send_word(input logic [15:0] w, input logic rdy);
    cycle(w[3:0], w[7:4], 1'b1, 1'b1, rdy, 1'b0);
    cycle(w[11:8], w[15:12], 1'b1, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    model_clear();
    @(posedge clk);
    n++;
    #8 rst = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    model_clear();
    #1 rst = 1'b1;
    #1;
    check("init_valid", 32'(bus.out_valid), 32'd0);
    check("init_data", 32'(bus.out_data), 32'd0);
    check("init_overflow", 32'(overflow), 32'd0);
    #11 rst = 1'b0;

    // single word, latency and one-cycle valid
    send_word(16'h4321, 1'b1);
    idle(1'b1, 1'b0);
    check("t1_early", 32'(bus.out_valid), 32'd0);
    idle(1'b1, 1'b0);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_data", 32'(bus.out_data), 32'h4321);
    idle(1'b1, 1'b0);
    check("t1_once", 32'(bus.out_valid), 32'd0);

    // continuous nibble stream
    for (int i = 0; i < 8; i++)
      cycle(4'(2 * i), 4'(2 * i + 1), 1'b1, i == 0, 1'b1, 1'b0);
    repeat (3) idle(1'b1, 1'b0);

    // overflow: third word dropped, then drain and clear
    send_word(16'h4321, 1'b0);
    send_word(16'h8765, 1'b0);
    send_word(16'hCBA9, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_head0", 32'(bus.out_data), 32'h4321);
    idle(1'b1, 1'b0);
    check("t3_head1", 32'(bus.out_data), 32'h8765);
    idle(1'b1, 1'b0);
    check("t3_empty", 32'(bus.out_valid), 32'd0);
    idle(1'b0, 1'b1);
    check("t3_clr", 32'(overflow), 32'd0);

    // full buffer with pop in the completing cycle
    send_word(16'h4321, 1'b0);
    send_word(16'h8765, 1'b0);
    send_word(16'hCBA9, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    check("t4_noovf", 32'(overflow), 32'd0);
    check("t4_head1", 32'(bus.out_data), 32'h8765);
    idle(1'b1, 1'b0);
    check("t4_head2", 32'(bus.out_data), 32'hCBA9);
    repeat (2) idle(1'b1, 1'b0);

    // en drop and sync mid-word
    cycle(4'h1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    send_word(16'h8765, 1'b1);
    cycle(4'h1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
    send_word(16'hA9B8, 1'b1);
    repeat (3) idle(1'b1, 1'b0);

    // reset mid-word and with buffered words
    cycle(4'h1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    cycle(4'h3, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(4'h5, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check("t6_word", 32'(bus.out_data), 32'h6543);
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b0);
    repeat (2) idle(1'b0, 1'b0);
    do_reset();
    repeat (2) idle(1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
